// File: rtl/prbs_gen_check.sv
// prbs_gen_check: parametrised PRBS generator / checker for AXI-Stream links.
//
// MODE "generator": drives M_AXIS with the LFSR state. Each accepted beat advances
//   the LFSR by STEP single-bit shifts. seed_load reloads the state, and a value of
//   zero is replaced by SEED.
// MODE "checker": self-synchronises to S_AXIS data (SEARCH), then free-runs a
//   prediction (LOCKED) and counts mismatching words and bits in saturating counters.
//
// Ports:
//   clk, aresetn             clock, asynchronous active-low reset
//   seed_load, seed_value    generator reload request and value
//   cnt_clear                checker: synchronous clear of both error counters
//   err_inject               (PRBS_ERR_INJECT_EN only) generator: invert bit 0 of the
//                            next transferred beat
//   S_AXIS_*                 checker input stream; TREADY is 1 from the first edge
//   M_AXIS_*                 generator output stream
//   locked                   checker lock indication
//   err_word_cnt/err_bit_cnt mismatching beats/bits seen while locked
//
// Build option: define PRBS_ERR_INJECT_EN to add the err_inject port and its logic.
module prbs_gen_check #(
  parameter int unsigned       LFSR_W       = 32,
  parameter logic [LFSR_W-1:0] POLY         = LFSR_W'(32'h80000057),
  parameter logic [LFSR_W-1:0] SEED         = '1,
  parameter int unsigned       STEP         = 1,
  parameter string             MODE         = "generator",
  parameter int unsigned       LOCK_COUNT   = 8,
  parameter int unsigned       UNLOCK_COUNT = 4,
  parameter int unsigned       CNT_W        = 32
) (
  input  logic              clk,
  input  logic              aresetn,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed_value,
  input  logic              cnt_clear,
`ifdef PRBS_ERR_INJECT_EN
  input  logic              err_inject,
`endif
  input  logic [LFSR_W-1:0] S_AXIS_TDATA,
  input  logic              S_AXIS_TVALID,
  output logic              S_AXIS_TREADY,
  output logic [LFSR_W-1:0] M_AXIS_TDATA,
  output logic              M_AXIS_TVALID,
  input  logic              M_AXIS_TREADY,
  output logic              locked,
  output logic [CNT_W-1:0]  err_word_cnt,
  output logic [CNT_W-1:0]  err_bit_cnt
);

  localparam bit          IsChk  = (MODE == "checker");
  localparam int unsigned MatchW = (LOCK_COUNT < 1) ? 1 : $clog2(LOCK_COUNT + 1);
  localparam int unsigned MissW  = (UNLOCK_COUNT < 1) ? 1 : $clog2(UNLOCK_COUNT + 1);
  // Wide enough for counter + popcount of a 64-bit word without overflow.
  localparam int unsigned SumW   = ((CNT_W > 7) ? CNT_W : 7) + 1;
  localparam logic [SumW-1:0]   CntMaxW   = SumW'({CNT_W{1'b1}});
  localparam logic [MatchW-1:0] LockCnt   = MatchW'(LOCK_COUNT);
  localparam logic [MissW-1:0]  UnlockCnt = MissW'(UNLOCK_COUNT);

  typedef enum logic [0:0] {StSearch, StLocked} chk_state_e;

  // STEP single-bit shifts unrolled into one combinational cone.
  function automatic logic [LFSR_W-1:0] lfsr_f(input logic [LFSR_W-1:0] x);
    logic [LFSR_W-1:0] s;
    s = x;
    for (int unsigned i = 0; i < STEP; i++) begin
      s = {s[LFSR_W-2:0], ^(s & POLY)};
    end
    return s;
  endfunction

  logic [LFSR_W-1:0] state_q, state_d;
  logic              tvalid_q, tvalid_d;
  logic              tready_q;
  logic              inj_q, inj_d;
  chk_state_e        st_q, st_d;
  logic [LFSR_W-1:0] prev_q, prev_d;
  logic              have_prev_q, have_prev_d;
  logic [MatchW-1:0] match_q, match_d;
  logic [MissW-1:0]  miss_q, miss_d;
  logic [LFSR_W-1:0] exp_q, exp_d;
  logic [CNT_W-1:0]  err_word_q, err_word_d;
  logic [CNT_W-1:0]  err_bit_q, err_bit_d;

  logic              xfer;
  logic              inj_req;
  logic [LFSR_W-1:0] pred;
  logic [LFSR_W-1:0] prev_next;
  logic [SumW-1:0]   bit_sum;

  assign xfer      = tvalid_q & M_AXIS_TREADY;
  assign pred      = lfsr_f(exp_q);
  assign prev_next = lfsr_f(prev_q);
  assign bit_sum   = SumW'(err_bit_q) + SumW'($countones(S_AXIS_TDATA ^ pred));

`ifdef PRBS_ERR_INJECT_EN
  assign inj_req = err_inject & ~IsChk;
`else
  assign inj_req = 1'b0;
`endif

  // Generator path.
  always_comb begin
    state_d  = state_q;
    tvalid_d = tvalid_q;
    inj_d    = inj_q;
    if (!IsChk) begin
      tvalid_d = 1'b1;
      if (seed_load) begin
        state_d = (seed_value == '0) ? SEED : seed_value;
      end else if (xfer) begin
        state_d = lfsr_f(state_q);
      end
      // One-shot flag: cleared by the transfer it corrupted, re-armed by a new pulse.
      inj_d = (inj_q & ~xfer) | inj_req;
    end
  end

  // Checker path.
  always_comb begin
    st_d        = st_q;
    prev_d      = prev_q;
    have_prev_d = have_prev_q;
    match_d     = match_q;
    miss_d      = miss_q;
    exp_d       = exp_q;
    err_word_d  = err_word_q;
    err_bit_d   = err_bit_q;
    if (IsChk && S_AXIS_TVALID) begin
      case (st_q)
        StSearch: begin
          if (have_prev_q && (S_AXIS_TDATA == prev_next)) begin
            match_d = match_q + MatchW'(1);
          end else begin
            match_d = '0;
          end
          prev_d      = S_AXIS_TDATA;
          have_prev_d = 1'b1;
          if (match_d == LockCnt) begin
            st_d   = StLocked;
            exp_d  = S_AXIS_TDATA;
            miss_d = '0;
          end
        end
        StLocked: begin
          // Prediction free-runs regardless of the received data.
          exp_d = pred;
          if (S_AXIS_TDATA != pred) begin
            err_word_d = (err_word_q == '1) ? err_word_q : err_word_q + CNT_W'(1);
            err_bit_d  = (bit_sum > CntMaxW) ? '1 : bit_sum[CNT_W-1:0];
            miss_d     = miss_q + MissW'(1);
            if (miss_d == UnlockCnt) begin
              st_d        = StSearch;
              match_d     = '0;
              prev_d      = S_AXIS_TDATA;
              have_prev_d = 1'b1;
            end
          end else begin
            miss_d = '0;
          end
        end
        default: st_d = StSearch;
      endcase
    end
    if (IsChk && cnt_clear) begin
      err_word_d = '0;
      err_bit_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= SEED;
      tvalid_q    <= 1'b0;
      tready_q    <= 1'b0;
      inj_q       <= 1'b0;
      st_q        <= StSearch;
      prev_q      <= '0;
      have_prev_q <= 1'b0;
      match_q     <= '0;
      miss_q      <= '0;
      exp_q       <= '0;
      err_word_q  <= '0;
      err_bit_q   <= '0;
    end else begin
      state_q     <= state_d;
      tvalid_q    <= tvalid_d;
      tready_q    <= 1'b1;
      inj_q       <= inj_d;
      st_q        <= st_d;
      prev_q      <= prev_d;
      have_prev_q <= have_prev_d;
      match_q     <= match_d;
      miss_q      <= miss_d;
      exp_q       <= exp_d;
      err_word_q  <= err_word_d;
      err_bit_q   <= err_bit_d;
    end
  end

  assign S_AXIS_TREADY = tready_q;
  assign M_AXIS_TVALID = tvalid_q;
  assign M_AXIS_TDATA  = state_q ^ LFSR_W'(inj_q);
  assign locked        = (st_q == StLocked);
  assign err_word_cnt  = err_word_q;
  assign err_bit_cnt   = err_bit_q;

endmodule

// File: tb/tb_prbs_gen_check.sv
// tb_prbs_gen_check: bench for prbs_gen_check with one generator instance (defaults)
// and one checker instance (CNT_W = 4). Expected values go into scoreboard queues
// when a cycle is driven and are compared after the following clock edge.
// Builds with or without PRBS_ERR_INJECT_EN.
module tb_prbs_gen_check;

  logic        clk;
  logic        aresetn;

  logic        g_seed_load;
  logic [31:0] g_seed_value;
  logic        g_m_tready;
  logic        g_inj;
  logic [31:0] g_m_tdata;
  logic        g_m_tvalid;
  logic        g_s_tready;
  logic        g_locked;
  logic [31:0] g_word;
  logic [31:0] g_bit;

  logic [31:0] c_tdata;
  logic        c_tvalid;
  logic        c_clr;
  logic        c_inj;
  logic        c_s_tready;
  logic [31:0] c_m_tdata;
  logic        c_m_tvalid;
  logic        c_locked;
  logic [3:0]  c_word;
  logic [3:0]  c_bit;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct { logic valid; logic [31:0] data; } gen_exp_t;
  typedef struct { logic locked; logic [3:0] word; logic [3:0] bits; } chk_exp_t;
  gen_exp_t gq[$];
  chk_exp_t cq[$];

  // Generator reference state.
  logic [31:0] gm_state;
  logic        gm_valid;
  logic        gm_inj;
  int          n_diff;
  logic [31:0] diff_acc;

  // Checker stimulus golden stream and expected counters.
  logic [31:0] cg;
  int          ew;
  int          eb;

  prbs_gen_check u_gen (
    .clk          (clk),
    .aresetn      (aresetn),
    .seed_load    (g_seed_load),
    .seed_value   (g_seed_value),
    .cnt_clear    (1'b0),
`ifdef PRBS_ERR_INJECT_EN
    .err_inject   (g_inj),
`endif
    .S_AXIS_TDATA (32'h0),
    .S_AXIS_TVALID(1'b0),
    .S_AXIS_TREADY(g_s_tready),
    .M_AXIS_TDATA (g_m_tdata),
    .M_AXIS_TVALID(g_m_tvalid),
    .M_AXIS_TREADY(g_m_tready),
    .locked       (g_locked),
    .err_word_cnt (g_word),
    .err_bit_cnt  (g_bit)
  );

  prbs_gen_check #(
    .MODE  ("checker"),
    .CNT_W (4)
  ) u_chk (
    .clk          (clk),
    .aresetn      (aresetn),
    .seed_load    (1'b0),
    .seed_value   (32'h0),
    .cnt_clear    (c_clr),
`ifdef PRBS_ERR_INJECT_EN
    .err_inject   (c_inj),
`endif
    .S_AXIS_TDATA (c_tdata),
    .S_AXIS_TVALID(c_tvalid),
    .S_AXIS_TREADY(c_s_tready),
    .M_AXIS_TDATA (c_m_tdata),
    .M_AXIS_TVALID(c_m_tvalid),
    .M_AXIS_TREADY(1'b1),
    .locked       (c_locked),
    .err_word_cnt (c_word),
    .err_bit_cnt  (c_bit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] prbs_f(input logic [31:0] x);
    return {x[30:0], ^(x & 32'h80000057)};
  endfunction

  function automatic int sat15(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  // One generator cycle, entered and left at a falling edge.
  task automatic gen_cycle(input logic rdy, input logic ld, input logic [31:0] sv,
                           input logic inj);
    gen_exp_t e;
    logic     xf;
    g_m_tready   = rdy;
    g_seed_load  = ld;
    g_seed_value = sv;
    g_inj        = inj;
    if (rdy && g_m_tvalid && (g_m_tdata !== gm_state)) begin
      n_diff++;
      diff_acc = diff_acc | (g_m_tdata ^ gm_state);
    end
    xf = gm_valid & rdy;
    if (ld) gm_state = (sv == 32'h0) ? 32'hFFFF_FFFF : sv;
    else if (xf) gm_state = prbs_f(gm_state);
`ifdef PRBS_ERR_INJECT_EN
    gm_inj = (gm_inj & ~xf) | inj;
`else
    gm_inj = 1'b0;
`endif
    gm_valid = 1'b1;
    e.valid = 1'b1;
    e.data  = gm_state ^ {31'h0, gm_inj};
    gq.push_back(e);
    @(negedge clk);
    e = gq.pop_front();
    check_eq("gen_tvalid", {63'h0, g_m_tvalid}, {63'h0, e.valid});
    check_eq("gen_tdata", {32'h0, g_m_tdata}, {32'h0, e.data});
    g_seed_load = 1'b0;
    g_inj       = 1'b0;
  endtask

  // One checker cycle with the expected post-edge lock state and counters.
  task automatic chk_beat(input logic v, input logic [31:0] d, input logic clr,
                          input logic el, input int xw, input int xb);
    chk_exp_t e;
    c_tvalid = v;
    c_tdata  = d;
    c_clr    = clr;
    e.locked = el;
    e.word   = 4'(xw);
    e.bits   = 4'(xb);
    cq.push_back(e);
    @(negedge clk);
    e = cq.pop_front();
    check_eq("chk_locked", {63'h0, c_locked}, {63'h0, e.locked});
    check_eq("chk_err_word", {60'h0, c_word}, {60'h0, e.word});
    check_eq("chk_err_bit", {60'h0, c_bit}, {60'h0, e.bits});
    c_tvalid = 1'b0;
    c_clr    = 1'b0;
  endtask

  function automatic logic [31:0] next_golden();
    logic [31:0] v;
    v  = cg;
    cg = prbs_f(cg);
    return v;
  endfunction

  initial begin
    logic [31:0] d;
    logic [31:0] r;
    int          beats;
    aresetn = 1'b0;
    g_seed_load = 1'b0; g_seed_value = 32'h0; g_m_tready = 1'b1; g_inj = 1'b0;
    c_tdata = 32'h0; c_tvalid = 1'b0; c_clr = 1'b0; c_inj = 1'b0;
    gm_state = 32'hFFFF_FFFF; gm_valid = 1'b0; gm_inj = 1'b0;
    n_diff = 0; diff_acc = 32'h0;
    cg = 32'h1357_9BDF; ew = 0; eb = 0;

    repeat (2) @(negedge clk);
    check_eq("rst_gen_tvalid", {63'h0, g_m_tvalid}, 64'h0);
    check_eq("rst_gen_tdata", {32'h0, g_m_tdata}, 64'hFFFF_FFFF);
    check_eq("rst_gen_s_tready", {63'h0, g_s_tready}, 64'h0);
    check_eq("rst_chk_s_tready", {63'h0, c_s_tready}, 64'h0);
    check_eq("rst_chk_locked", {63'h0, c_locked}, 64'h0);
    aresetn = 1'b1;

    // Generator: first beats after reset, backpressure, reload.
    gen_cycle(1'b1, 1'b0, 32'h0, 1'b0);
    check_eq("beat0", {32'h0, g_m_tdata}, 64'hFFFF_FFFF);
    check_eq("gen_s_tready_up", {63'h0, g_s_tready}, 64'h1);
    check_eq("chk_s_tready_up", {63'h0, c_s_tready}, 64'h1);
    check_eq("chk_m_tvalid_low", {63'h0, c_m_tvalid}, 64'h0);
    gen_cycle(1'b1, 1'b0, 32'h0, 1'b0);
    check_eq("beat1", {32'h0, g_m_tdata}, 64'hFFFF_FFFE);
    gen_cycle(1'b1, 1'b0, 32'h0, 1'b0);
    check_eq("beat2", {32'h0, g_m_tdata}, 64'hFFFF_FFFD);
    repeat (5) gen_cycle(1'b0, 1'b0, 32'h0, 1'b0);
    check_eq("hold", {32'h0, g_m_tdata}, 64'hFFFF_FFFD);
    gen_cycle(1'b1, 1'b1, 32'h0, 1'b0);
    check_eq("load_zero", {32'h0, g_m_tdata}, 64'hFFFF_FFFF);
    gen_cycle(1'b1, 1'b1, 32'h1234_5678, 1'b0);
    check_eq("load_value", {32'h0, g_m_tdata}, 64'h1234_5678);
    for (int i = 0; i < 20; i++) gen_cycle(1'($urandom_range(1)), 1'b0, 32'h0, 1'b0);
`ifdef PRBS_ERR_INJECT_EN
    n_diff = 0; diff_acc = 32'h0;
    gen_cycle(1'b0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 8; i++) gen_cycle(1'b1, 1'b0, 32'h0, 1'b0);
    check_eq("inj_beats", 64'(n_diff), 64'd1);
    check_eq("inj_bits", {32'h0, diff_acc}, 64'h1);
`endif
    check_eq("gen_locked_low", {63'h0, g_locked}, 64'h0);
    check_eq("gen_cnt_low", {g_word, g_bit}, 64'h0);

    // Checker: lock on the 9th beat, then 1000 clean beats with idle gaps.
    for (int k = 1; k <= 9; k++) begin
      d = next_golden();
      chk_beat(1'b1, d, 1'b0, (k >= 9), 0, 0);
    end
    beats = 9;
    while (beats < 1000) begin
      if ($urandom_range(3) == 0) chk_beat(1'b0, $urandom, 1'b0, 1'b1, 0, 0);
      else begin
        d = next_golden();
        chk_beat(1'b1, d, 1'b0, 1'b1, 0, 0);
        beats++;
      end
    end

    // Single 3-bit error, following beats still match.
    d = next_golden();
    ew = 1; eb = 3;
    chk_beat(1'b1, d ^ 32'h0001_0204, 1'b0, 1'b1, ew, eb);
    for (int k = 0; k < 5; k++) chk_beat(1'b1, next_golden(), 1'b0, 1'b1, ew, eb);

    // Clear wins over a simultaneous error.
    ew = 0; eb = 0;
    chk_beat(1'b1, next_golden() ^ 32'h8000_0000, 1'b1, 1'b1, ew, eb);
    chk_beat(1'b1, next_golden(), 1'b0, 1'b1, ew, eb);

    // Saturation: 20 two-bit errors interleaved with good beats.
    for (int i = 0; i < 20; i++) begin
      ew = sat15(ew + 1);
      eb = sat15(eb + 2);
      chk_beat(1'b1, next_golden() ^ 32'h0000_0003, 1'b0, 1'b1, ew, eb);
      chk_beat(1'b1, next_golden(), 1'b0, 1'b1, ew, eb);
    end
    ew = 0; eb = 0;
    chk_beat(1'b0, 32'h0, 1'b1, 1'b1, ew, eb);

    // Four random beats drop lock; a clean stream relocks after 9 beats.
    for (int i = 1; i <= 4; i++) begin
      d = next_golden();
      r = $urandom;
      if (r == d) r = r ^ 32'h1;
      ew = sat15(ew + 1);
      eb = sat15(eb + $countones(r ^ d));
      chk_beat(1'b1, r, 1'b0, (i < 4), ew, eb);
    end
    for (int k = 1; k <= 9; k++) begin
      if (k == 5) chk_beat(1'b0, $urandom, 1'b0, 1'b0, ew, eb);
      chk_beat(1'b1, next_golden(), 1'b0, (k >= 9), ew, eb);
    end
    ew = 0; eb = 0;
    chk_beat(1'b1, next_golden() ^ 32'h0000_0010, 1'b1, 1'b1, ew, eb);
    ew = 1; eb = 2;
    chk_beat(1'b1, next_golden() ^ 32'h0000_0030, 1'b0, 1'b1, ew, eb);

    // Asynchronous reset mid-operation.
    aresetn = 1'b0;
    #1;
    check_eq("mid_rst_locked", {63'h0, c_locked}, 64'h0);
    check_eq("mid_rst_word", {60'h0, c_word}, 64'h0);
    check_eq("mid_rst_bit", {60'h0, c_bit}, 64'h0);
    check_eq("mid_rst_s_tready", {63'h0, c_s_tready}, 64'h0);
    check_eq("mid_rst_gen_tvalid", {63'h0, g_m_tvalid}, 64'h0);
    check_eq("mid_rst_gen_tdata", {32'h0, g_m_tdata}, 64'hFFFF_FFFF);
    @(negedge clk);
    aresetn = 1'b1;
    @(negedge clk);
    check_eq("rerelease_s_tready", {63'h0, c_s_tready}, 64'h1);
    check_eq("rerelease_gen_tvalid", {63'h0, g_m_tvalid}, 64'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
